// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write bus for the instruction encoder/loader.
// master: the request producer, which also observes the imem write side.
// slave : the loader itself.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        mnem;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, mnem, rs, rt, rd, funct, imm, target,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, mnem, rs, rt, rd, funct, imm, target,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Boot/program loader: turns symbolic instruction requests into 32-bit words
// using the control unit's opcode map and writes them to imem at an
// auto-incrementing address.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  S_IDLE | waiting for a request; in_ready when not full and no start
//  S_ENC  | encode captured fields into imem_wdata, or flag illegal
//  S_WR   | imem_we high for this one cycle at imem_addr = pointer
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    instr_encoder_loader_if.slave  bus,
    output logic [ADDR_W:0]        instr_count,
    output logic                   full,
    output logic                   illegal
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [4:0]        MNEM_NUM = 5'd18;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               full_q, full_d;
    logic               illegal_q, illegal_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [4:0]         mnem_q, mnem_d;
    logic [4:0]         rs_q, rs_d;
    logic [4:0]         rt_q, rt_d;
    logic [4:0]         rd_q, rd_d;
    logic [5:0]         funct_q, funct_d;
    logic [15:0]        imm_q, imm_d;
    logic [25:0]        target_q, target_d;

    logic in_ready;
    logic accept;

    // Opcode map shared with the control unit's decoder.
    function automatic logic [31:0] encode(
        input logic [4:0]  m,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [5:0]  f_funct,
        input logic [15:0] f_imm,
        input logic [25:0] f_target
    );
        logic [31:0] w;
        w = 32'd0;
        case (m)
            5'd0:  w = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, f_funct};
            5'd1:  w = {6'b000000, f_rs, 15'd0, 6'd1};
            5'd2:  w = {6'b100011, f_rs, f_rt, f_imm};
            5'd3:  w = {6'b001111, f_rs, f_rt, f_imm};
            5'd4:  w = {6'b110001, f_rs, f_rt, f_imm};
            5'd5:  w = {6'b111000, f_rs, f_rt, f_imm};
            5'd6:  w = {6'b001110, f_rs, f_rt, f_imm};
            5'd7:  w = {6'b001100, f_rs, f_rt, f_imm};
            5'd8:  w = {6'b001000, f_rs, f_rt, f_imm};
            5'd9:  w = {6'b100000, f_rs, f_rt, f_imm};
            5'd10: w = {6'b100010, f_rs, f_rt, f_imm};
            5'd11: w = {6'b100101, f_rs, f_rt, f_imm};
            5'd12: w = {6'b000111, f_rs, f_rt, f_imm};
            // BRZ compares rs against zero, so the rt slot is forced to r0.
            5'd13: w = {6'b000110, f_rs, 5'd0, f_imm};
            5'd14: w = {6'b110100, f_target};
            5'd15: w = {6'b111110, f_target};
            5'd16: w = {6'b010001, f_rs, f_rt, f_imm};
            5'd17: w = {6'b011001, f_rs, f_rt, f_imm};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // start wins over a same-cycle request, so it also gates in_ready.
    assign in_ready = (state_q == S_IDLE) && !full_q && !start;
    assign accept   = bus.in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start aborts any in-flight request.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = S_ENC;
                S_ENC:   state_d = (mnem_q >= MNEM_NUM) ? S_IDLE : S_WR;
                S_WR:    state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next values: field capture, encoding, pointer/count/flags.
    always_comb begin
        ptr_d     = ptr_q;
        count_d   = count_q;
        full_d    = full_q;
        illegal_d = illegal_q;
        wdata_d   = wdata_q;
        mnem_d    = mnem_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        funct_d   = funct_q;
        imm_d     = imm_q;
        target_d  = target_q;
        if (accept) begin
            mnem_d   = bus.mnem;
            rs_d     = bus.rs;
            rt_d     = bus.rt;
            rd_d     = bus.rd;
            funct_d  = bus.funct;
            imm_d    = bus.imm;
            target_d = bus.target;
        end
        if (start) begin
            ptr_d     = BASE;
            count_d   = '0;
            full_d    = 1'b0;
            illegal_d = 1'b0;
        end else begin
            case (state_q)
                S_ENC: begin
                    if (mnem_q >= MNEM_NUM) begin
                        illegal_d = 1'b1;
                    end else begin
                        wdata_d = encode(mnem_q, rs_q, rt_q, rd_q, funct_q, imm_q, target_q);
                    end
                end
                S_WR: begin
                    ptr_d   = ptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_d == CAPACITY) full_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= BASE;
            count_q   <= '0;
            full_q    <= 1'b0;
            illegal_q <= 1'b0;
            wdata_q   <= '0;
            mnem_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            funct_q   <= '0;
            imm_q     <= '0;
            target_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            illegal_q <= illegal_d;
            wdata_q   <= wdata_d;
            mnem_q    <= mnem_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            funct_q   <= funct_d;
            imm_q     <= imm_d;
            target_q  <= target_d;
        end
    end

    // Outputs; the strobe is squashed by start so an abort in S_WR never writes.
    always_comb begin
        bus.in_ready   = in_ready;
        bus.imem_we    = (state_q == S_WR) && !start;
        bus.imem_addr  = ptr_q;
        bus.imem_wdata = wdata_q;
        instr_count    = count_q;
        full           = full_q;
        illegal        = illegal_q;
    end

endmodule
